// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared types and width helpers for the frame-RAM port arbiter.
package ram_arb_pkg;

   typedef enum logic {ARB_IDLE, ARB_BURST} arb_state_t;

   function automatic int gnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int cnt_w(input int max_burst);
      return $clog2(max_burst + 1);
   endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin priority encoder, first set bit at or after ptr with wrap.
module rr_pick #(
   parameter int N = 2,
   parameter int W = 1
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic         any,
   output logic [W-1:0] pick
);

   // scanning from the far end lets the nearest requester overwrite earlier hits
   always_comb begin
      any  = |req;
      pick = '0;
      for (int k = N - 1; k >= 0; k--)
         if (req[(32'(ptr) + k) % N]) pick = W'((32'(ptr) + k) % N);
   end

endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: round-robin, burst-locked sharing of one single-port RAM
// with read data returned to the issuing requester a fixed RD_LAT cycles later.
module ram_port_arbiter
   import ram_arb_pkg::*;
#(
   parameter  int NUM_REQ   = 2,
   parameter  int ADDR_W    = 10,
   parameter  int DATA_W    = 32,
   parameter  int MAX_BURST = 16,
   parameter  int RD_LAT    = 1,
   localparam int GW        = gnt_w(NUM_REQ),
   localparam int CW        = cnt_w(MAX_BURST)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ-1:0]        req_we,
   input  logic [NUM_REQ-1:0]        req_last,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic [NUM_REQ-1:0]        rsp_valid,
   output logic [DATA_W-1:0]         rsp_data,
   output logic                      ram_en,
   output logic                      ram_we,
   output logic [ADDR_W-1:0]         ram_addr,
   output logic [DATA_W-1:0]         ram_wdata,
   input  logic [DATA_W-1:0]         ram_rdata,
   output logic [GW-1:0]             grant_id,
   output logic                      busy
);

   arb_state_t          state;
   logic [GW-1:0]       rr_ptr, pick;
   logic [CW-1:0]       beat_cnt;
   logic                any, beat, rel;
   logic [RD_LAT-1:0]   tag_v;
   logic [GW-1:0]       tag_id [RD_LAT];

   rr_pick #(.N(NUM_REQ), .W(GW)) u_pick (
      .req (req_valid),
      .ptr (rr_ptr),
      .any (any),
      .pick(pick)
   );

   always_comb begin
      busy      = state == ARB_BURST;
      beat      = busy && req_valid[grant_id];
      rel       = busy && (!req_valid[grant_id] || req_last[grant_id] || 32'(beat_cnt) + 1 == MAX_BURST);
      req_ready = busy ? NUM_REQ'(1) << grant_id : '0;
      ram_en    = beat;
      ram_we    = beat && req_we[grant_id];
      ram_addr  = beat ? req_addr[grant_id*ADDR_W +: ADDR_W] : '0;
      ram_wdata = beat ? req_wdata[grant_id*DATA_W +: DATA_W] : '0;
      rsp_valid = tag_v[RD_LAT-1] ? NUM_REQ'(1) << tag_id[RD_LAT-1] : '0;
      rsp_data  = ram_rdata;
   end

   // a busy cycle that does not release is necessarily a beat
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ARB_IDLE;
         rr_ptr   <= '0;
         grant_id <= '0;
         beat_cnt <= '0;
      end else if (!busy) begin
         if (any) begin
            state    <= ARB_BURST;
            grant_id <= pick;
            beat_cnt <= '0;
         end
      end else if (rel) begin
         state  <= ARB_IDLE;
         rr_ptr <= (32'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + 1'b1;
      end else begin
         beat_cnt <= beat_cnt + 1'b1;
      end
   end

   // read tags travel alongside the RAM latency, independent of arbitration state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tag_v <= '0;
         for (int k = 0; k < RD_LAT; k++) tag_id[k] <= '0;
      end else begin
         tag_v[0]  <= beat && !req_we[grant_id];
         tag_id[0] <= grant_id;
         for (int k = 1; k < RD_LAT; k++) begin
            tag_v[k]  <= tag_v[k-1];
            tag_id[k] <= tag_id[k-1];
         end
      end
   end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: directed and random requester traffic checked cycle by
// cycle against a transaction-level arbitration and memory model.
module tb_ram_port_arbiter;

   localparam int N  = 3;
   localparam int AW = 10;
   localparam int DW = 32;
   localparam int MB = 16;
   localparam int RL = 2;
   localparam int GW = 2;

   typedef struct {
      bit            idle;
      bit            we;
      bit            last;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } beat_t;

   typedef struct {
      int            due;
      int            id;
      logic [DW-1:0] data;
   } rsp_t;

   logic            clk = 0;
   logic            rst = 1;
   logic [N-1:0]    req_valid, req_we, req_last, req_ready, rsp_valid;
   logic [N*AW-1:0] req_addr;
   logic [N*DW-1:0] req_wdata;
   logic [DW-1:0]   rsp_data, ram_wdata, ram_rdata;
   logic            ram_en, ram_we, busy;
   logic [AW-1:0]   ram_addr;
   logic [GW-1:0]   grant_id;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ram_port_arbiter #(
      .NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB), .RD_LAT(RL)
   ) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_we(req_we), .req_last(req_last),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data),
      .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
      .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
      .grant_id(grant_id), .busy(busy)
   );

   function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
      return 32'hA500_0000 ^ (32'(a) * 32'h0001_0203);
   endfunction

   // RAM macro model with RL-cycle read latency
   logic [DW-1:0] ram [1024];
   bit            wr  [1024];
   logic [DW-1:0] rdp [RL];
   always @(posedge clk) begin
      if (ram_en && ram_we) begin
         ram[ram_addr] <= ram_wdata;
         wr[ram_addr]  <= 1'b1;
      end
      rdp[0] <= wr[ram_addr] ? ram[ram_addr] : init_val(ram_addr);
      for (int k = 1; k < RL; k++) rdp[k] <= rdp[k-1];
   end
   assign ram_rdata = rdp[RL-1];

   // reference model state
   beat_t         q [N][$];
   rsp_t          rq [$];
   logic [DW-1:0] shadow [1024];
   bit            m_busy, m_beat;
   int            m_gid, m_ptr, m_cnt, cyc;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic push_beat(input int i, input bit we, input bit last, input logic [AW-1:0] a, input logic [DW-1:0] d);
      beat_t b;
      b.idle = 0; b.we = we; b.last = last; b.addr = a; b.data = d;
      q[i].push_back(b);
   endtask

   task automatic push_idle(input int i);
      beat_t b;
      b.idle = 1; b.we = 0; b.last = 0; b.addr = '0; b.data = '0;
      q[i].push_back(b);
   endtask

   function automatic bit pending();
      bit p = m_busy || rq.size() > 0;
      for (int i = 0; i < N; i++) if (q[i].size() > 0) p = 1;
      return p;
   endfunction

   task automatic clear_inputs();
      req_valid = '0; req_we = '0; req_last = '0; req_addr = '0; req_wdata = '0;
   endtask

   // non-owner lanes carry junk so that ignored inputs really are ignored
   task automatic drive();
      for (int i = 0; i < N; i++) begin
         if (q[i].size() > 0 && !q[i][0].idle) begin
            req_valid[i]            = 1'b1;
            req_we[i]               = q[i][0].we;
            req_last[i]             = q[i][0].last;
            req_addr[i*AW +: AW]    = q[i][0].addr;
            req_wdata[i*DW +: DW]   = q[i][0].data;
         end else begin
            req_valid[i]            = 1'b0;
            req_we[i]               = 1'($urandom_range(0, 1));
            req_last[i]             = 1'($urandom_range(0, 1));
            req_addr[i*AW +: AW]    = AW'($urandom);
            req_wdata[i*DW +: DW]   = $urandom;
         end
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_ready"}, req_ready, 0);
      check({tag, "_rsp_valid"}, rsp_valid, 0);
      check({tag, "_ram_en"}, ram_en, 0);
      check({tag, "_ram_we"}, ram_we, 0);
      check({tag, "_ram_addr"}, ram_addr, 0);
      check({tag, "_ram_wdata"}, ram_wdata, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_grant_id"}, grant_id, 0);
   endtask

   task automatic half_a();
      logic [N-1:0] er, ev;
      @(negedge clk);
      drive();
      #1;
      er = m_busy ? N'(1) << m_gid : '0;
      m_beat = m_busy && req_valid[m_gid];
      check("ready", req_ready, er);
      check("busy", busy, m_busy);
      check("grant_id", grant_id, m_gid);
      check("ram_en", ram_en, m_beat);
      if (m_beat) begin
         check("ram_we", ram_we, q[m_gid][0].we);
         check("ram_addr", ram_addr, q[m_gid][0].addr);
         if (q[m_gid][0].we) check("ram_wdata", ram_wdata, q[m_gid][0].data);
      end
      ev = (rq.size() > 0 && rq[0].due == cyc) ? N'(1) << rq[0].id : '0;
      check("rsp_valid", rsp_valid, ev);
      if (ev != 0) check("rsp_data", rsp_data, rq[0].data);
   endtask

   task automatic half_b();
      beat_t b;
      logic [N-1:0] vv;
      @(posedge clk);
      vv = req_valid;
      for (int i = 0; i < N; i++) if (q[i].size() > 0 && q[i][0].idle) void'(q[i].pop_front());
      if (m_beat) begin
         b = q[m_gid].pop_front();
         if (b.we) shadow[b.addr] = b.data;
         else rq.push_back('{cyc + RL, m_gid, shadow[b.addr]});
      end
      if (rq.size() > 0 && rq[0].due == cyc) void'(rq.pop_front());
      if (!m_busy) begin
         for (int k = 0; k < N; k++)
            if (vv[(m_ptr + k) % N]) begin
               m_busy = 1; m_gid = (m_ptr + k) % N; m_cnt = 0;
               break;
            end
      end else if (!m_beat || b.last || m_cnt + 1 == MB) begin
         m_busy = 0;
         m_ptr  = (m_gid + 1) % N;
      end else begin
         m_cnt++;
      end
      cyc++;
   endtask

   task automatic run(input int budget);
      int n = 0;
      while (pending() && n < budget) begin
         half_a(); half_b(); n++;
      end
      check("drained", pending(), 0);
      repeat (2) begin half_a(); half_b(); end
   endtask

   task automatic do_reset();
      #1 rst = 1;
      #1 check_zero("rst_now");
      clear_inputs();
      m_busy = 0; m_gid = 0; m_ptr = 0; m_cnt = 0;
      rq.delete();
      for (int i = 0; i < N; i++) q[i].delete();
      @(negedge clk);
      check_zero("rst_hold");
      rst = 0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int len;
      bit nolast;
      for (int k = 0; k < 1024; k++) shadow[k] = init_val(AW'(k));
      clear_inputs();
      repeat (3) @(negedge clk);
      check_zero("por");
      do_reset();

      for (int k = 0; k < 4; k++) push_beat(0, 0, k == 3, AW'(10'h010 + k), '0);
      run(100);

      do_reset();
      for (int b = 0; b < 2; b++) begin
         push_beat(0, 0, 0, AW'(10'h020 + 2*b), '0);
         push_beat(0, 0, 1, AW'(10'h021 + 2*b), '0);
         push_beat(1, 1, 0, AW'(10'h030 + 2*b), $urandom);
         push_beat(1, 1, 1, AW'(10'h031 + 2*b), $urandom);
      end
      run(100);

      for (int k = 0; k < 20; k++) push_beat(1, 1, 0, AW'(10'h100 + k), $urandom);
      run(200);

      do_reset();
      push_beat(0, 0, 0, 10'h100, '0);
      push_beat(0, 0, 0, 10'h101, '0);
      push_idle(0);
      push_beat(0, 0, 1, 10'h102, '0);
      push_beat(1, 0, 0, 10'h103, '0);
      push_beat(1, 0, 1, 10'h104, '0);
      run(100);

      push_beat(0, 1, 0, 10'h3FF, 32'hDEADBEEF);
      push_beat(0, 0, 1, 10'h3FF, '0);
      run(100);

      for (int k = 0; k < 6; k++) push_beat(0, 0, k == 5, AW'(10'h040 + k), '0);
      for (int n = 0; n < 50; n++) begin
         half_a();
         if (m_busy && m_gid == 0 && m_cnt == 2) break;
         half_b();
      end
      check("third_beat_reached", {m_busy, m_cnt[7:0]}, {1'b1, 8'd2});
      do_reset();
      push_beat(1, 0, 1, 10'h050, '0);
      push_beat(0, 0, 1, 10'h051, '0);
      run(100);

      for (int r = 0; r < 150; r++) begin
         int i = $urandom_range(0, N - 1);
         repeat ($urandom_range(0, 2)) push_idle(i);
         len    = $urandom_range(1, 20);
         nolast = $urandom_range(0, 5) == 0;
         for (int k = 0; k < len; k++) begin
            if ($urandom_range(0, 9) == 0) push_idle(i);
            push_beat(i, 1'($urandom_range(0, 1)), (k == len - 1) && !nolast,
                      AW'($urandom_range(0, 31)), $urandom);
         end
      end
      run(20000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
